// File: rtl/codec_pkg.sv
// Shared constants and state encoding for the WM8731
// power-up sequencer and its register table.
package codec_pkg;

  localparam logic [7:0] WM8731_DEV_ADDR = 8'h34;

  localparam logic [6:0] R0_LLINE_IN   = 7'h00;
  localparam logic [6:0] R1_RLINE_IN   = 7'h01;
  localparam logic [6:0] R2_LHP_OUT    = 7'h02;
  localparam logic [6:0] R3_RHP_OUT    = 7'h03;
  localparam logic [6:0] R4_ANA_PATH   = 7'h04;
  localparam logic [6:0] R5_DIG_PATH   = 7'h05;
  localparam logic [6:0] R6_PWR_DOWN   = 7'h06;
  localparam logic [6:0] R7_DIG_FMT    = 7'h07;
  localparam logic [6:0] R8_SAMPLING   = 7'h08;
  localparam logic [6:0] R9_ACTIVE     = 7'h09;
  localparam logic [6:0] R15_RESET     = 7'h0F;

  localparam int INIT_TABLE_LEN = 11;

  typedef enum logic [2:0] {
    S_SETTLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_GAP,
    S_READY,
    S_HOST_WAIT
  } state_e;

  function automatic logic [15:0] reg_word(
    input logic [6:0] addr,
    input logic [8:0] data
  );
    return {addr, data};
  endfunction

  function automatic logic is_busy(input state_e s);
    return (s == S_SETTLE)    || (s == S_ISSUE) ||
           (s == S_WAIT_ACK)  || (s == S_WAIT_DONE) ||
           (s == S_GAP);
  endfunction

endpackage

// File: rtl/codec_init_rom.sv
// WM8731 power-up register table, indexed in issue order.
// Entries past the end read as zero.
module codec_init_rom
  import codec_pkg::*;
(
  input  logic [3:0]  idx_i,
  output logic [15:0] entry_o
);

  always_comb begin
    entry_o = 16'h0000;
    case (idx_i)
      4'd0:    entry_o = reg_word(R15_RESET,   9'h000);
      4'd1:    entry_o = reg_word(R0_LLINE_IN, 9'h017);
      4'd2:    entry_o = reg_word(R1_RLINE_IN, 9'h017);
      4'd3:    entry_o = reg_word(R2_LHP_OUT,  9'h079);
      4'd4:    entry_o = reg_word(R3_RHP_OUT,  9'h079);
      4'd5:    entry_o = reg_word(R4_ANA_PATH, 9'h012);
      4'd6:    entry_o = reg_word(R5_DIG_PATH, 9'h000);
      4'd7:    entry_o = reg_word(R6_PWR_DOWN, 9'h000);
      // I2S, 24-bit slave
      4'd8:    entry_o = reg_word(R7_DIG_FMT,  9'h00A);
      4'd9:    entry_o = reg_word(R8_SAMPLING, 9'h000);
      4'd10:   entry_o = reg_word(R9_ACTIVE,   9'h001);
      default: entry_o = 16'h0000;
    endcase
  end

endmodule

// File: rtl/codec_init_sequencer.sv
// Runs the WM8731 init table over the I2C engine, then
// arbitrates the engine for host packets one at a time.
module codec_init_sequencer
  import codec_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR      = WM8731_DEV_ADDR,
  parameter int         SETTLE_CYCLES = 1000,
  parameter int         GAP_CYCLES    = 16,
  parameter int         ACK_TIMEOUT   = 255
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        start,
  input  logic        host_req,
  input  logic [23:0] host_packet,
  output logic        host_grant,
  input  logic        i2c_idle,
  output logic        wr_i2c,
  output logic [23:0] i2c_packet,
  output logic        init_busy,
  output logic        init_done,
  output logic        init_error,
  output logic [3:0]  init_index
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST    = GW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(ACK_TIMEOUT - 1);
  localparam logic [3:0]    LAST_IDX    = 4'(INIT_TABLE_LEN - 1);

  state_e        state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [TW-1:0] to_q, to_d;
  logic          hlow_q, hlow_d;
  logic [3:0]    idx_q, idx_d;
  logic [23:0]   pkt_q, pkt_d;
  logic          wr_q, wr_d;
  logic          grant_q, grant_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [15:0]   rom_entry;

  codec_init_rom u_rom (
    .idx_i   (idx_q),
    .entry_o (rom_entry)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= S_SETTLE;
      settle_q <= '0;
      gap_q    <= '0;
      to_q     <= '0;
      hlow_q   <= 1'b0;
      idx_q    <= '0;
      pkt_q    <= '0;
      wr_q     <= 1'b0;
      grant_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      gap_q    <= gap_d;
      to_q     <= to_d;
      hlow_q   <= hlow_d;
      idx_q    <= idx_d;
      pkt_q    <= pkt_d;
      wr_q     <= wr_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    gap_d    = gap_q;
    to_d     = to_q;
    hlow_d   = hlow_q;
    idx_d    = idx_q;
    pkt_d    = pkt_q;
    wr_d     = 1'b0;
    grant_d  = 1'b0;
    done_d   = done_q;
    err_d    = err_q;

    unique case (state_q)
      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = S_ISSUE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end

      S_ISSUE: begin
        if (i2c_idle) begin
          wr_d    = 1'b1;
          pkt_d   = {DEV_ADDR, rom_entry};
          to_d    = '0;
          state_d = S_WAIT_ACK;
        end
      end

      S_WAIT_ACK: begin
        if (!i2c_idle) begin
          state_d = S_WAIT_DONE;
        end else if (to_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_READY;
        end else begin
          to_d = to_q + 1'b1;
        end
      end

      S_WAIT_DONE: begin
        if (i2c_idle) begin
          gap_d   = '0;
          state_d = S_GAP;
        end
      end

      S_GAP: begin
        if (gap_q != GAP_LAST) begin
          gap_d = gap_q + 1'b1;
        end else if (idx_q == LAST_IDX) begin
          done_d  = 1'b1;
          state_d = S_READY;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_ISSUE;
        end
      end

      // start outranks a pending host request
      S_READY: begin
        if (start) begin
          done_d   = 1'b0;
          err_d    = 1'b0;
          idx_d    = '0;
          settle_d = '0;
          state_d  = S_SETTLE;
        end else if (host_req && i2c_idle) begin
          grant_d = 1'b1;
          wr_d    = 1'b1;
          pkt_d   = host_packet;
          to_d    = '0;
          hlow_d  = 1'b0;
          state_d = S_HOST_WAIT;
        end
      end

      S_HOST_WAIT: begin
        if (!hlow_q) begin
          if (!i2c_idle) begin
            hlow_d = 1'b1;
          end else if (to_q == TO_LAST) begin
            err_d   = 1'b1;
            state_d = S_READY;
          end else begin
            to_d = to_q + 1'b1;
          end
        end else if (i2c_idle) begin
          state_d = S_READY;
        end
      end

      default: state_d = S_SETTLE;
    endcase

    busy_d = is_busy(state_d);
  end

  assign wr_i2c     = wr_q;
  assign i2c_packet = pkt_q;
  assign host_grant = grant_q;
  assign init_busy  = busy_q;
  assign init_done  = done_q;
  assign init_error = err_q;
  assign init_index = idx_q;

endmodule

// File: tb/tb_codec_init_sequencer.sv
// Bench for codec_init_sequencer: engine model drives i2c_idle,
// expected packets are queued and matched against every wr_i2c.
module tb_codec_init_sequencer;

  localparam int SETTLE = 1000;
  localparam int GAP    = 16;
  localparam int TO     = 255;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        start = 1'b0;
  logic        host_req = 1'b0;
  logic [23:0] host_packet = 24'h0;
  logic        host_grant;
  logic        i2c_idle;
  logic        wr_i2c;
  logic [23:0] i2c_packet;
  logic        init_busy;
  logic        init_done;
  logic        init_error;
  logic [3:0]  init_index;

  codec_init_sequencer #(
    .DEV_ADDR      (8'h34),
    .SETTLE_CYCLES (SETTLE),
    .GAP_CYCLES    (GAP),
    .ACK_TIMEOUT   (TO)
  ) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .start       (start),
    .host_req    (host_req),
    .host_packet (host_packet),
    .host_grant  (host_grant),
    .i2c_idle    (i2c_idle),
    .wr_i2c      (wr_i2c),
    .i2c_packet  (i2c_packet),
    .init_busy   (init_busy),
    .init_done   (init_done),
    .init_error  (init_error),
    .init_index  (init_index)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [23:0] pkt;
    logic        grant;
    int          idx;
  } exp_t;

  typedef struct {
    logic [3:0]  idx;
    logic [23:0] pkt;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[11];
  int   total = 0;
  int   bad = 0;
  int   nwr = 0;
  int   stuck_idx = -1;
  bit   force_low = 1'b0;
  logic prev_wr = 1'b0;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // engine: idle falls 2 cycles after wr, rises 20 later
  initial begin
    i2c_idle = 1'b1;
    forever begin
      @(negedge Clk);
      if (force_low) begin
        i2c_idle = 1'b0;
      end else if (Rst_n && wr_i2c &&
                   int'(init_index) != stuck_idx) begin
        i2c_idle = 1'b1;
        @(negedge Clk);
        i2c_idle = 1'b0;
        repeat (20) @(negedge Clk);
        i2c_idle = 1'b1;
      end else begin
        i2c_idle = 1'b1;
      end
    end
  end

  always @(negedge Clk) begin
    exp_t e;
    if (Rst_n) begin
      if (wr_i2c) begin
        nwr++;
        check("wr back-to-back", 32'(prev_wr), 32'd0);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected write: got %h want none",
                   i2c_packet);
        end else begin
          e = sb.pop_front();
          check("packet", 32'(i2c_packet), 32'(e.pkt));
          check("grant with write", 32'(host_grant),
                32'(e.grant));
          if (e.idx >= 0)
            check("index at write", 32'(init_index),
                  32'(e.idx));
        end
      end else if (host_grant) begin
        total++;
        bad++;
        $display("FAIL grant without write: got 1 want 0");
      end
      prev_wr = wr_i2c;
    end else begin
      prev_wr = 1'b0;
    end
  end

  task automatic push_table(int n);
    for (int i = 0; i < n; i++)
      sb.push_back('{tbl[i].pkt, 1'b0, int'(tbl[i].idx)});
  endtask

  task automatic push_host(logic [23:0] p);
    sb.push_back('{p, 1'b1, -1});
  endtask

  task automatic check_reset_outs(string tag);
    check({tag, " wr"}, 32'(wr_i2c), 32'd0);
    check({tag, " pkt"}, 32'(i2c_packet), 32'd0);
    check({tag, " grant"}, 32'(host_grant), 32'd0);
    check({tag, " busy"}, 32'(init_busy), 32'd0);
    check({tag, " done"}, 32'(init_done), 32'd0);
    check({tag, " error"}, 32'(init_error), 32'd0);
    check({tag, " index"}, 32'(init_index), 32'd0);
  endtask

  task automatic release_and_time(string name);
    int n = 0;
    @(negedge Clk);
    Rst_n = 1'b1;
    while (n < 3000) begin
      @(posedge Clk);
      #1;
      n++;
      if (n == 1)
        check("busy after release", 32'(init_busy), 32'd1);
      if (wr_i2c) break;
    end
    check(name, 32'(n), 32'(SETTLE + 1));
  endtask

  task automatic wait_done(string name);
    int n = 0;
    while (!init_done && n < 5000) begin
      @(negedge Clk);
      n++;
    end
    check(name, 32'(init_done), 32'd1);
    check({name, " busy"}, 32'(init_busy), 32'd0);
  endtask

  task automatic wait_grant(string name);
    int n = 0;
    while (!host_grant && n < 200) begin
      @(negedge Clk);
      n++;
    end
    check(name, 32'(host_grant), 32'd1);
    host_req = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge Clk);
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    check("done cleared by start", 32'(init_done), 32'd0);
    check("busy after start", 32'(init_busy), 32'd1);
    check("index after start", 32'(init_index), 32'd0);
  endtask

  initial begin
    int n;
    int k;
    tbl[0]  = '{4'd0,  24'h341E00};
    tbl[1]  = '{4'd1,  24'h340017};
    tbl[2]  = '{4'd2,  24'h340217};
    tbl[3]  = '{4'd3,  24'h340479};
    tbl[4]  = '{4'd4,  24'h340679};
    tbl[5]  = '{4'd5,  24'h340812};
    tbl[6]  = '{4'd6,  24'h340A00};
    tbl[7]  = '{4'd7,  24'h340C00};
    tbl[8]  = '{4'd8,  24'h340E0A};
    tbl[9]  = '{4'd9,  24'h341000};
    tbl[10] = '{4'd10, 24'h341201};

    #1;
    check_reset_outs("reset");

    // full table with host request pending throughout
    push_table(11);
    push_host(24'h340A06);
    host_packet = 24'h340A06;
    host_req = 1'b1;
    repeat (3) @(negedge Clk);
    release_and_time("first write latency");
    wait_done("run1 done");
    check("run1 error", 32'(init_error), 32'd0);
    check("run1 index", 32'(init_index), 32'd10);
    check("host pending at done", 32'(sb.size()), 32'd1);
    wait_grant("host grant after done");
    repeat (40) @(negedge Clk);
    check("run1 queue drained", 32'(sb.size()), 32'd0);

    // start and host_req in the same READY cycle
    push_table(11);
    push_host(24'h340A06);
    @(negedge Clk);
    start = 1'b1;
    host_req = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    check("start wins: done", 32'(init_done), 32'd0);
    check("start wins: busy", 32'(init_busy), 32'd1);
    check("start wins: no grant", 32'(host_grant), 32'd0);
    wait_done("run2 done");
    wait_grant("deferred grant");
    repeat (40) @(negedge Clk);

    // engine ignores the 3rd write
    stuck_idx = 2;
    push_table(3);
    pulse_start();
    n = 0;
    while (n < 3000) begin
      @(posedge Clk);
      #1;
      n++;
      if (wr_i2c && init_index == 4'd2) break;
    end
    n = 0;
    while (!init_error && n < 1000) begin
      @(posedge Clk);
      #1;
      n++;
    end
    check("ack timeout cycles", 32'(n), 32'(TO));
    check("timeout index", 32'(init_index), 32'd2);
    check("timeout done", 32'(init_done), 32'd0);
    check("timeout busy", 32'(init_busy), 32'd0);
    stuck_idx = -1;
    push_host(24'h34ABCD);
    host_packet = 24'h34ABCD;
    host_req = 1'b1;
    @(negedge Clk);
    wait_grant("grant after timeout");
    repeat (40) @(negedge Clk);
    check("error sticky", 32'(init_error), 32'd1);

    // reset during WAIT_DONE of entry 5
    push_table(6);
    pulse_start();
    check("error cleared by start", 32'(init_error), 32'd0);
    n = 0;
    while (!(wr_i2c && init_index == 4'd5) && n < 3000) begin
      @(negedge Clk);
      n++;
    end
    repeat (5) @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    check_reset_outs("async reset");
    check("queue at reset", 32'(sb.size()), 32'd0);
    push_table(11);
    repeat (3) @(negedge Clk);
    release_and_time("latency after abort");
    wait_done("run after abort done");

    // idle held low while the sequencer sits in ISSUE
    push_table(11);
    force_low = 1'b1;
    pulse_start();
    k = nwr;
    repeat (SETTLE + 50) @(negedge Clk);
    check("no write while idle low", 32'(nwr - k), 32'd0);
    @(posedge Clk);
    #1;
    force_low = 1'b0;
    @(negedge Clk);
    @(posedge Clk);
    #1;
    check("write on first idle", 32'(wr_i2c), 32'd1);
    check("first write packet", 32'(i2c_packet),
          32'h00341E00);
    wait_done("run after idle low done");
    repeat (5) @(negedge Clk);
    check("final queue drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
